// File: rtl/phy_fault_injector.sv
// PCS/PHY tx fault injector: corrupt/garbage/strip-K/freeze/link-kill; optional PHY_FAULT_INJ_DISPARITY_EN.
// Latency: one register, input word of cycle t appears on the outputs in cycle t+1.
// Backpressure: none; one word per clock, requests during an injection or link kill are dropped.
module phy_fault_injector #(
  parameter logic [15:0] g_lfsr_seed   = 16'hACE1,
  parameter int          g_count_width = 16
) (
  input  logic                     clk_ref_i,
  input  logic                     rst_n_i,
  input  logic [15:0]              tx_data_i,
  input  logic [1:0]               tx_k_i,
  input  logic                     link_en_i,
  input  logic [15:0]              fault_type_i,
  input  logic                     fault_req_i,
  output logic                     fault_busy_o,
  output logic [15:0]              tx_data_o,
  output logic [1:0]               tx_k_o,
  output logic                     tx_enc_err_o,
  output logic [g_count_width-1:0] fault_cnt_o
`ifdef PHY_FAULT_INJ_DISPARITY_EN
  ,
  output logic                     tx_disparity_o
`endif
);

  typedef enum logic {S_IDLE, S_INJECT} state_t;

  localparam logic [15:0] c_seed = (g_lfsr_seed == 16'h0000) ? 16'hACE1 : g_lfsr_seed;
  localparam logic [g_count_width-1:0] c_one = {{(g_count_width-1){1'b0}}, 1'b1};

  state_t                   r_state;
  logic [2:0]               r_mode;
  logic [7:0]               r_rem;
  logic [15:0]              r_lfsr;
  logic [15:0]              r_frz_data;
  logic [1:0]               r_frz_k;
  logic [15:0]              r_data;
  logic [1:0]               r_k;
  logic                     r_err;
  logic                     r_busy;
  logic [g_count_width-1:0] r_cnt;

  logic [2:0]  w_req_mode;
  logic [7:0]  w_req_len;
  logic        w_start;
  logic        w_lfsr_fb;
  logic [15:0] w_data_nxt;
  logic [1:0]  w_k_nxt;
  logic        w_err_nxt;
  logic        w_unused_rsvd;

  assign w_req_mode    = fault_type_i[2:0];
  assign w_req_len     = fault_type_i[15:8];
  assign w_unused_rsvd = ^fault_type_i[7:3];
  assign w_lfsr_fb     = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];
  assign w_start       = (r_state == S_IDLE) && fault_req_i && link_en_i &&
                         (w_req_mode >= 3'd1) && (w_req_mode <= 3'd4);

  always_comb begin
    w_data_nxt = tx_data_i;
    w_k_nxt    = tx_k_i;
    w_err_nxt  = 1'b0;
    if (!link_en_i) begin
      // 2'b11 on an all-zero word is never a legal K pair, so the far end sees a dead link
      w_data_nxt = 16'h0000;
      w_k_nxt    = 2'b11;
      w_err_nxt  = 1'b1;
    end else if (r_state == S_INJECT) begin
      w_err_nxt = 1'b1;
      case (r_mode)
        3'd1: w_data_nxt = tx_data_i ^ r_lfsr;
        3'd2: begin
          w_data_nxt = r_lfsr;
          w_k_nxt    = 2'b00;
        end
        3'd3: w_k_nxt = 2'b00;
        default: begin
          w_data_nxt = r_frz_data;
          w_k_nxt    = r_frz_k;
        end
      endcase
    end
  end

  always_ff @(posedge clk_ref_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state    <= S_IDLE;
      r_mode     <= 3'd0;
      r_rem      <= 8'd0;
      r_lfsr     <= c_seed;
      r_frz_data <= 16'h0000;
      r_frz_k    <= 2'b00;
      r_data     <= 16'h0000;
      r_k        <= 2'b00;
      r_err      <= 1'b0;
      r_busy     <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_lfsr <= {w_lfsr_fb, r_lfsr[15:1]};
      r_data <= w_data_nxt;
      r_k    <= w_k_nxt;
      r_err  <= w_err_nxt;
      if (!link_en_i) begin
        // link kill aborts without counting
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
        r_rem   <= 8'd0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_start) begin
              r_state    <= S_INJECT;
              r_busy     <= 1'b1;
              r_mode     <= w_req_mode;
              r_rem      <= (w_req_len == 8'd0) ? 8'd1 : w_req_len;
              r_frz_data <= tx_data_i;
              r_frz_k    <= tx_k_i;
            end
          end
          S_INJECT: begin
            r_rem <= r_rem - 8'd1;
            if (r_rem == 8'd1) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_cnt   <= r_cnt + c_one;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign tx_data_o    = r_data;
  assign tx_k_o       = r_k;
  assign tx_enc_err_o = r_err;
  assign fault_busy_o = r_busy;
  assign fault_cnt_o  = r_cnt;

`ifdef PHY_FAULT_INJ_DISPARITY_EN
  // unbalanced 5b/6b data codes and 3b/4b codes, indexed by the EDCBA / HGF fields
  localparam logic [31:0] c_flip5 = 32'hE981_8117;
  localparam logic [7:0]  c_flip3 = 8'h91;

  logic r_disp;
  logic w_disp_nxt;

  function automatic logic f_flip(input logic [7:0] b, input logic k);
    if (k && (b[1:0] != 2'b00))
      return 1'b0;
    if (k)
      return 1'b1 ^ c_flip3[b[7:5]];
    return c_flip5[b[4:0]] ^ c_flip3[b[7:5]];
  endfunction

  assign w_disp_nxt = link_en_i ?
                      (r_disp ^ f_flip(w_data_nxt[15:8], w_k_nxt[1]) ^ f_flip(w_data_nxt[7:0], w_k_nxt[0])) :
                      1'b0;

  always_ff @(posedge clk_ref_i or negedge rst_n_i) begin
    if (!rst_n_i)
      r_disp <= 1'b0;
    else
      r_disp <= w_disp_nxt;
  end

  assign tx_disparity_o = r_disp;
`endif

endmodule

// File: tb/tb_phy_fault_injector.sv
`timescale 1ns/1ps
module tb_phy_fault_injector;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] tx_data;
  logic [1:0]  tx_k;
  logic        link_en;
  logic [15:0] ftype;
  logic        req;
  logic        busy;
  logic [15:0] dout;
  logic [1:0]  kout;
  logic        err;
  logic [15:0] cnt;
`ifdef PHY_FAULT_INJ_DISPARITY_EN
  logic        disp;
`endif

  int total = 0;
  int bad   = 0;

  logic [15:0] seq [0:8191];

  always #5 clk = ~clk;

  phy_fault_injector #(.g_lfsr_seed(16'hACE1), .g_count_width(16)) dut (
    .clk_ref_i    (clk),
    .rst_n_i      (rst_n),
    .tx_data_i    (tx_data),
    .tx_k_i       (tx_k),
    .link_en_i    (link_en),
    .fault_type_i (ftype),
    .fault_req_i  (req),
    .fault_busy_o (busy),
    .tx_data_o    (dout),
    .tx_k_o       (kout),
    .tx_enc_err_o (err),
    .fault_cnt_o  (cnt)
`ifdef PHY_FAULT_INJ_DISPARITY_EN
    ,
    .tx_disparity_o (disp)
`endif
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", name, got, want, $time);
    end
  endtask

  // Does this byte's 8b10b code have non-zero disparity (i.e. flip running disparity)?
  function automatic logic flips(input logic [7:0] b, input logic k);
    int  x5;
    int  y3;
    logic six_unbal;
    logic four_unbal;
    x5 = int'(b[4:0]);
    y3 = int'(b[7:5]);
    if (k && b[1:0] != 2'b00) return 1'b0;
    six_unbal  = k ? 1'b1 : (x5 inside {0, 1, 2, 4, 8, 15, 16, 23, 24, 27, 29, 30, 31});
    four_unbal = (y3 inside {0, 4, 7});
    return six_unbal ^ four_unbal;
  endfunction

  // Reference LFSR sequence: value in force during the n-th clock after reset release
  initial begin
    logic [15:0] s;
    logic        fb;
    s = 16'hACE1;
    for (int i = 0; i < 8192; i++) begin
      seq[i] = s;
      fb = (s ^ (s >> 2) ^ (s >> 3) ^ (s >> 5)) & 16'h1;
      s  = (s >> 1) | (16'(fb) << 15);
    end
  end

  int          cyc;
  int          left;
  logic [2:0]  m_mode;
  logic [15:0] m_frz;
  logic [1:0]  m_frzk;
  logic [15:0] m_cnt;
  logic        m_disp;
  logic [15:0] e_data;
  logic [1:0]  e_k;
  logic        e_err;
  logic        e_busy;

  always @(posedge clk) begin
    if (!rst_n) begin
      cyc    = 0;
      left   = 0;
      m_cnt  = 16'h0;
      m_disp = 1'b0;
    end else begin
      e_err  = 1'b1;
      e_busy = 1'b0;
      if (!link_en) begin
        e_data = 16'h0000;
        e_k    = 2'b11;
        left   = 0;
      end else if (left > 0) begin
        case (m_mode)
          3'd1: begin e_data = tx_data ^ seq[cyc]; e_k = tx_k;  end
          3'd2: begin e_data = seq[cyc];           e_k = 2'b00; end
          3'd3: begin e_data = tx_data;            e_k = 2'b00; end
          default: begin e_data = m_frz;           e_k = m_frzk; end
        endcase
        left = left - 1;
        if (left == 0) m_cnt = m_cnt + 16'h1;
        else e_busy = 1'b1;
      end else begin
        e_data = tx_data;
        e_k    = tx_k;
        e_err  = 1'b0;
        if (req && ftype[2:0] >= 3'd1 && ftype[2:0] <= 3'd4) begin
          m_mode = ftype[2:0];
          left   = (ftype[15:8] == 8'd0) ? 1 : int'(ftype[15:8]);
          m_frz  = tx_data;
          m_frzk = tx_k;
          e_busy = 1'b1;
        end
      end
      m_disp = link_en ? (m_disp ^ flips(e_data[15:8], e_k[1]) ^ flips(e_data[7:0], e_k[0])) : 1'b0;
      cyc = cyc + 1;
      #1;
      check("data", dout, e_data);
      check("k", kout, e_k);
      check("enc_err", err, e_err);
      check("busy", busy, e_busy);
      check("cnt", cnt, m_cnt);
`ifdef PHY_FAULT_INJ_DISPARITY_EN
      check("disparity", disp, m_disp);
`endif
    end
  end

  initial begin
    rst_n   = 1'b0;
    tx_data = 16'hBC50;
    tx_k    = 2'b10;
    link_en = 1'b1;
    ftype   = 16'h0000;
    req     = 1'b0;
    repeat (3) @(negedge clk);

    // reset state and model pins
    check("rst_data", dout, 16'h0000);
    check("rst_k", kout, 2'b00);
    check("rst_err", err, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_cnt", cnt, 16'h0);
    check("lfsr_seq1", seq[1], 16'h5670);
    check("lfsr_seq2", seq[2], 16'hAB38);
    check("flip_k28_5", flips(8'hBC, 1'b1), 1'b1);
    check("flip_d16_2", flips(8'h50, 1'b0), 1'b1);
    check("flip_k27_7", flips(8'hFB, 1'b1), 1'b0);
    check("flip_d10_2", flips(8'h4A, 1'b0), 1'b0);

    rst_n = 1'b1;
    @(posedge clk); #2;
    check("t1_data", dout, 16'hBC50);
    check("t1_k", kout, 2'b10);
    check("t1_err", err, 1'b0);
    check("t1_cnt", cnt, 16'h0);
    @(negedge clk);

    // mode 3, N=0: one word stripped of K
    ftype = 16'h0003; req = 1'b1;
    @(posedge clk); #2;
    check("t2_busy_rise", busy, 1'b1);
    @(negedge clk); req = 1'b0;
    @(posedge clk); #2;
    check("t2_k", kout, 2'b00);
    check("t2_data", dout, 16'hBC50);
    check("t2_err", err, 1'b1);
    check("t2_busy_fall", busy, 1'b0);
    check("t2_cnt", cnt, 16'h1);
    @(negedge clk);

    // mode 2, N=5, second request during busy
    ftype = 16'h0502; req = 1'b1;
    @(negedge clk); req = 1'b0;
    @(negedge clk); req = 1'b1;
    @(negedge clk); req = 1'b0;
    repeat (6) @(negedge clk);
    check("t3_cnt", cnt, 16'h2);

    // mode 4, N=3, request on the 1234 word of a ramp
    ftype = 16'h0304;
    for (int i = 0; i < 10; i++) begin
      tx_data = 16'h1230 + 16'(i);
      tx_k    = 2'b00;
      req     = (i == 4);
      @(negedge clk);
    end
    req = 1'b0;
    check("t4_cnt", cnt, 16'h3);

    // mode 2, N=10, link killed after 4 words
    tx_data = 16'h0F0F;
    ftype = 16'h0A02; req = 1'b1;
    @(negedge clk); req = 1'b0;
    repeat (4) @(negedge clk);
    link_en = 1'b0; req = 1'b1;
    @(posedge clk); #2;
    check("t5_data", dout, 16'h0000);
    check("t5_k", kout, 2'b11);
    check("t5_err", err, 1'b1);
    check("t5_busy", busy, 1'b0);
    check("t5_cnt", cnt, 16'h3);
`ifdef PHY_FAULT_INJ_DISPARITY_EN
    check("t5_disp", disp, 1'b0);
`endif
    @(negedge clk); req = 1'b0;
    @(negedge clk);
    link_en = 1'b1; tx_data = 16'h5A5A; tx_k = 2'b00;
    @(posedge clk); #2;
    check("t5_resume_data", dout, 16'h5A5A);
    check("t5_resume_err", err, 1'b0);
    check("t5_resume_busy", busy, 1'b0);
    @(negedge clk);

`ifdef PHY_FAULT_INJ_DISPARITY_EN
    for (int i = 0; i < 24; i++) begin
      tx_data = i[0] ? 16'h50BC : 16'hBC50;
      tx_k    = i[0] ? 2'b01 : 2'b10;
      if (i == 7) tx_data = 16'h5050;
      if (i == 8) tx_k = 2'b11;
      link_en = !(i >= 12 && i < 15);
      @(negedge clk);
    end
    link_en = 1'b1;
`endif

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      tx_data = 16'($urandom);
      tx_k    = 2'($urandom);
      link_en = ($urandom_range(0, 59) != 0) ? 1'b1 : (i[3] ? 1'b0 : 1'b1);
      req     = ($urandom_range(0, 5) == 0);
      ftype   = {8'($urandom_range(0, 6)), 5'($urandom), 3'($urandom_range(0, 7))};
      @(negedge clk);
    end
    req = 1'b0;
    link_en = 1'b1;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/phy_fault_injector.md
Name: phy_fault_injector

Overview:
- Synthesizable fault-injection stage on the 16-bit PCS/PHY transmit path, between an endpoint's tx_data/tx_k outputs and the switch's rd_i lane.
- Passes symbols through with one register of latency. On command it corrupts, replaces, de-Ks or freezes symbols for a programmable word count, or forces a link-kill pattern.
- Gives benches and board-level tests repeatable link-error stimulus driven by a 16-bit failure-type word.

Parameters:
g_lfsr_seed, 16'hACE1, initial LFSR state; a value of 0 is replaced by 16'hACE1.
g_count_width, 16, width of the completed-injection counter.

Ports:
clk_ref_i  in  1  PHY reference clock; the only clock.
rst_n_i  in  1  reset, asynchronous, active-low.
tx_data_i  in  16  symbol pair from the endpoint; [15:8] is sent first.
tx_k_i  in  2  K flags for tx_data_i; [1] pairs with [15:8].
link_en_i  in  1  0 = link killed.
fault_type_i  in  16  [2:0] mode, [15:8] length N, [7:3] reserved.
fault_req_i  in  1  single-cycle request strobe.
fault_busy_o  out  1  injection in progress.
tx_data_o  out  16  symbols toward the switch.
tx_k_o  out  2  K flags toward the switch.
tx_enc_err_o  out  1  output word is not pass-through.
fault_cnt_o  out  g_count_width  number of completed injections; wraps.

Behaviour:
- Reset values:
  - tx_data_o=16'h0000, tx_k_o=2'b00, tx_enc_err_o=0, fault_busy_o=0, fault_cnt_o=0.
  - LFSR=g_lfsr_seed; FSM=IDLE.
- Latency: every output is registered. The input in cycle t appears at the output in cycle t+1.
- LFSR: 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1. It advances every cycle after reset and never reaches zero.
- FSM states are IDLE and INJECT, with a remaining-word counter rem (8 bits).
- IDLE:
  - fault_req_i=1 with mode 1..4 and link_en_i=1: latch mode, set rem=max(N,1), go to INJECT.
  - fault_busy_o rises in the next cycle.
  - Modes 0 and 5..7 are ignored: no state change, no count.
- INJECT, one input word processed per cycle:
  - mode 1 (corrupt): data_o=data_i XOR lfsr, k_o=k_i.
  - mode 2 (garbage): data_o=lfsr, k_o=2'b00.
  - mode 3 (strip K): data_o=data_i, k_o=2'b00.
  - mode 4 (freeze): data_o and k_o repeat the word captured in the request cycle.
  - tx_enc_err_o=1 for every injected word.
  - rem decrements each cycle. The cycle in which rem=1 is the last injected word: the FSM returns to IDLE, fault_cnt_o increments, and fault_busy_o falls in the next cycle.
  - Mode 1 with N>1 corrupts N consecutive words.
- fault_req_i while in INJECT is ignored and not queued. A request in the same cycle the FSM returns to IDLE is also ignored.
- Link kill:
  - link_en_i=0 overrides everything: output 16'h0000 with k=2'b11 (not a valid K pair) and tx_enc_err_o=1, starting one cycle after link_en_i falls.
  - An injection in progress aborts to IDLE and is not counted; fault_busy_o falls the next cycle.
  - Requests while link_en_i=0 are ignored.
  - Pass-through resumes one cycle after link_en_i rises.
- fault_cnt_o wraps from all-ones to 0.

Optional Feature:
- Macro PHY_FAULT_INJ_DISPARITY_EN.
- Defined:
  - Adds output tx_disparity_o (1 bit, reset 0).
  - It gives the running 8b10b disparity after the registered output word, computed [15:8] first then [7:0] using the standard 5b/6b and 3b/4b disparity-flip tables. K bytes other than K.28-class (data[1:0]!=0) do not flip.
  - It updates in the same cycle as tx_data_o and is reset to 0 when link_en_i=0.
- Undefined: the port and its logic are absent.

Test Plan:
1. Reset release with tx_data_i=16'hBC50, k=2'b10 held: output 16'hBC50/2'b10 from the second clock, tx_enc_err_o=0, fault_cnt_o=0.
2. fault_type_i=16'h0003 (mode 3, N=0), one-cycle request while streaming idles: exactly 1 word has k=00 and tx_enc_err_o=1; busy high 1 cycle; fault_cnt_o=1.
3. fault_type_i=16'h0502 (garbage, N=5) with seed 16'hACE1: 5 outputs match the reference LFSR sequence with k=00; a second request during busy is ignored; fault_cnt_o increments by 1.
4. Mode 4, N=3, request in the cycle tx_data_i=16'h1234: 3 outputs of 16'h1234 while the input ramps, then pass-through resumes.
5. Mode 2, N=10, link_en_i dropped after 4 words: 16'h0000/2'b11 from the next cycle, busy falls, fault_cnt_o unchanged; link_en_i restored gives pass-through after 1 cycle.
6. With PHY_FAULT_INJ_DISPARITY_EN: alternate K28.5 D16.2 pairs; tx_disparity_o matches the software 8b10b model every cycle, and is 0 during link kill.
